// File: rtl/regfile_onehot_wr.sv
// 31x WIDTH register file with a one-hot write select, two combinational read ports,
// same-cycle write-through bypass, register 31 hardwired to zero and malformed-select tracking.
module regfile_onehot_wr #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wr_en,
  input  logic [31:0]      i_wr_sel,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [4:0]       i_rd_addr1,
  input  logic [4:0]       i_rd_addr2,
  output logic [WIDTH-1:0] o_rd_data1,
  output logic [WIDTH-1:0] o_rd_data2,
  output logic             o_sel_err,
  output logic [7:0]       o_err_count
);

  localparam int unsigned NumRegs = 31;

  logic [WIDTH-1:0] r_regs [NumRegs];
  logic             r_sel_err;
  logic [7:0]       r_err_count;

  logic             w_sel_any;
  logic             w_sel_multi;
  logic             w_sel_onehot;
  logic             w_wr_valid;
  logic             w_wr_bad;
  logic             w_wr_store;
  logic [4:0]       w_wr_idx;
  logic [WIDTH-1:0] w_rd_data1;
  logic [WIDTH-1:0] w_rd_data2;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_sel_any    = |i_wr_sel;
  assign w_sel_multi  = |(i_wr_sel & (i_wr_sel - 32'd1));
  assign w_sel_onehot = w_sel_any & ~w_sel_multi;

  assign w_wr_valid = i_wr_en & w_sel_onehot;
  assign w_wr_bad   = i_wr_en & ~w_sel_onehot;
  assign w_wr_store = w_wr_valid & ~i_wr_sel[31];

  // OR-encoder; only meaningful when the select is one-hot.
  always_comb begin
    w_wr_idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (i_wr_sel[i]) begin
        w_wr_idx = w_wr_idx | 5'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_store) begin
      for (int i = 0; i < NumRegs; i++) begin
        if (i_wr_sel[i]) begin
          r_regs[i] <= i_wr_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sel_err   <= 1'b0;
      r_err_count <= 8'd0;
    end else if (w_wr_bad) begin
      r_sel_err <= 1'b1;
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  // Address 31 matches no storage entry and so falls through to zero.
  always_comb begin
    w_rd_data1 = '0;
    w_rd_data2 = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (i_rd_addr1 == 5'(i)) begin
        w_rd_data1 = r_regs[i];
      end
      if (i_rd_addr2 == 5'(i)) begin
        w_rd_data2 = r_regs[i];
      end
    end
    if (i_reset_n && w_wr_store && (w_wr_idx == i_rd_addr1)) begin
      w_rd_data1 = i_wr_data;
    end
    if (i_reset_n && w_wr_store && (w_wr_idx == i_rd_addr2)) begin
      w_rd_data2 = i_wr_data;
    end
  end

  assign o_rd_data1  = w_rd_data1;
  assign o_rd_data2  = w_rd_data2;
  assign o_sel_err   = r_sel_err;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed self-checking bench for regfile_onehot_wr: reset, writes, bypass, malformed selects,
// counter saturation, asynchronous reset and back-to-back writes.
module tb_regfile_onehot_wr;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [31:0] wr_sel;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [63:0] rd_data1;
  logic [63:0] rd_data2;
  logic        sel_err;
  logic [7:0]  err_count;

  int n_pass;
  int n_total;

  regfile_onehot_wr #(.WIDTH(64)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_wr_en     (wr_en),
    .i_wr_sel    (wr_sel),
    .i_wr_data   (wr_data),
    .i_rd_addr1  (rd_addr1),
    .i_rd_addr2  (rd_addr2),
    .o_rd_data1  (rd_data1),
    .o_rd_data2  (rd_data2),
    .o_sel_err   (sel_err),
    .o_err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns 1 ns after a rising edge, leaving inputs free to change away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    #3;
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #1;
      n_total++;
      if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0)
        $display("FAIL reset_read a=%0d: got %h/%h, want 0/0", a, rd_data1, rd_data2);
      else n_pass++;
    end
    n_total++;
    if (sel_err !== 1'b0 || err_count !== 8'd0)
      $display("FAIL reset_err: got %b/%0d, want 0/0", sel_err, err_count);
    else n_pass++;
    tick();
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    wr_en    = 1'b1;
    wr_sel   = 32'h0000_0020;
    wr_data  = 64'hDEAD_BEEF_0000_0005;
    rd_addr1 = 5'd4;
    rd_addr2 = 5'd6;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0)
      $display("FAIL write_neighbors_same_cycle: got %h/%h, want 0/0", rd_data1, rd_data2);
    else n_pass++;
    tick();
    wr_en    = 1'b0;
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd4;
    #1;
    n_total++;
    if (rd_data1 !== 64'hDEAD_BEEF_0000_0005)
      $display("FAIL write_r5: got %h, want deadbeef00000005", rd_data1);
    else n_pass++;
    n_total++;
    if (rd_data2 !== 64'd0) $display("FAIL write_r4: got %h, want 0", rd_data2);
    else n_pass++;
    rd_addr2 = 5'd6;
    #1;
    n_total++;
    if (rd_data2 !== 64'd0) $display("FAIL write_r6: got %h, want 0", rd_data2);
    else n_pass++;
  endtask

  task automatic test_bypass();
    wr_en    = 1'b1;
    wr_sel   = 32'h0000_0080;
    wr_data  = 64'h1234;
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd7;
    #1;
    n_total++;
    if (rd_data1 !== 64'h1234 || rd_data2 !== 64'h1234)
      $display("FAIL bypass_both: got %h/%h, want 1234/1234", rd_data1, rd_data2);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    #1;
    n_total++;
    if (rd_data1 !== 64'h1234) $display("FAIL bypass_stored_r7: got %h, want 1234", rd_data1);
    else n_pass++;
    // Write to register 31: no bypass, no storage, no error.
    wr_en    = 1'b1;
    wr_sel   = 32'h8000_0000;
    wr_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_addr1 = 5'd31;
    rd_addr2 = 5'd5;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0) $display("FAIL r31_bypass: got %h, want 0", rd_data1);
    else n_pass++;
    n_total++;
    if (rd_data2 !== 64'hDEAD_BEEF_0000_0005)
      $display("FAIL r31_no_alias: got %h, want deadbeef00000005", rd_data2);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0) $display("FAIL r31_stored: got %h, want 0", rd_data1);
    else n_pass++;
    n_total++;
    if (sel_err !== 1'b0 || err_count !== 8'd0)
      $display("FAIL r31_err: got %b/%0d, want 0/0", sel_err, err_count);
    else n_pass++;
  endtask

  task automatic test_malformed();
    wr_en    = 1'b1;
    wr_sel   = 32'h0000_0003;
    wr_data  = 64'hAAAA_AAAA_AAAA_AAAA;
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd1;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0)
      $display("FAIL multi_no_bypass: got %h/%h, want 0/0", rd_data1, rd_data2);
    else n_pass++;
    n_total++;
    if (sel_err !== 1'b0) $display("FAIL err_before_edge: got %b, want 0", sel_err);
    else n_pass++;
    tick();
    wr_sel   = 32'h0;
    rd_addr1 = 5'd7;
    #1;
    n_total++;
    if (rd_data1 !== 64'h1234) $display("FAIL zero_sel_no_bypass: got %h, want 1234", rd_data1);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    rd_addr1 = 5'd0;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0)
      $display("FAIL multi_no_store: got %h/%h, want 0/0", rd_data1, rd_data2);
    else n_pass++;
    n_total++;
    if (sel_err !== 1'b1 || err_count !== 8'd2)
      $display("FAIL malformed_err: got %b/%0d, want 1/2", sel_err, err_count);
    else n_pass++;
    wr_sel = 32'hFFFF_FFFF;
    tick();
    tick();
    n_total++;
    if (err_count !== 8'd2) $display("FAIL wr_en_low_ignored: got %0d, want 2", err_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    wr_en  = 1'b1;
    wr_sel = 32'h0000_0000;
    for (int i = 0; i < 252; i++) tick();
    n_total++;
    if (err_count !== 8'd254) $display("FAIL sat_254: got %0d, want 254", err_count);
    else n_pass++;
    tick();
    n_total++;
    if (err_count !== 8'd255) $display("FAIL sat_255: got %0d, want 255", err_count);
    else n_pass++;
    for (int i = 0; i < 47; i++) tick();
    wr_en = 1'b0;
    n_total++;
    if (err_count !== 8'd255 || sel_err !== 1'b1)
      $display("FAIL sat_hold: got %b/%0d, want 1/255", sel_err, err_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    wr_en   = 1'b1;
    wr_sel  = 32'h0000_0001;
    wr_data = 64'h0000_0000_0000_0A00;
    tick();
    wr_sel  = 32'h0000_8000;
    wr_data = 64'h0000_0000_0000_0F15;
    tick();
    wr_sel  = 32'h4000_0000;
    wr_data = 64'h0000_0000_0000_0E30;
    tick();
    wr_en    = 1'b0;
    rd_addr1 = 5'd15;
    rd_addr2 = 5'd30;
    #1;
    n_total++;
    if (rd_data1 !== 64'hF15 || rd_data2 !== 64'hE30)
      $display("FAIL pre_reset_r15_r30: got %h/%h, want f15/e30", rd_data1, rd_data2);
    else n_pass++;
    #1;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0)
      $display("FAIL async_r15_r30: got %h/%h, want 0/0", rd_data1, rd_data2);
    else n_pass++;
    rd_addr1 = 5'd0;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0) $display("FAIL async_r0: got %h, want 0", rd_data1);
    else n_pass++;
    n_total++;
    if (sel_err !== 1'b0 || err_count !== 8'd0)
      $display("FAIL async_err: got %b/%0d, want 0/0", sel_err, err_count);
    else n_pass++;
    // Write attempted while held in reset: lost, and no bypass.
    wr_en    = 1'b1;
    wr_sel   = 32'h0000_8000;
    wr_data  = 64'h5555;
    rd_addr1 = 5'd15;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0) $display("FAIL reset_no_bypass: got %h, want 0", rd_data1);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
    n_total++;
    if (rd_data1 !== 64'd0) $display("FAIL reset_write_lost: got %h, want 0", rd_data1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    tick();
    wr_en    = 1'b1;
    wr_sel   = 32'h0000_0008;
    wr_data  = 64'h1111;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd3;
    tick();
    wr_data = 64'h2222;
    #1;
    n_total++;
    if (rd_data1 !== 64'h2222) $display("FAIL b2b_bypass: got %h, want 2222", rd_data1);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    #1;
    n_total++;
    if (rd_data1 !== 64'h2222 || rd_data2 !== 64'h2222)
      $display("FAIL b2b_last_wins: got %h/%h, want 2222/2222", rd_data1, rd_data2);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_write();
    test_bypass();
    test_malformed();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
